// File: rtl/loop_lock_monitor.sv
// Lock supervisor for the carrier/bit-sync loop filter.
// Smooths |error|, runs acquisition FSM, drives sweep magnitude.
module loop_lock_monitor #(
   parameter int AVG_SHIFT = 6,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clkEn,
   input  logic                 enable,
   input  logic [7:0]           error,
   input  logic [31:0]          lagAccum,
   input  logic [31:0]          limit,
   input  logic [31:0]          sweepRate,
   input  logic [15:0]          lockThresh,
   input  logic [15:0]          unlockThresh,
   input  logic [CNT_WIDTH-1:0] lockCount,
   input  logic [CNT_WIDTH-1:0] unlockCount,
   output logic [31:0]          sweepOffsetMag,
   output logic                 locked,
   output logic [1:0]           state,
   output logic [15:0]          avgErrMag
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWEEP  = 2'd1,
      VERIFY = 2'd2,
      LOCKED = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [15:0]          avg_q, avg_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]          sweep_q, sweep_d;
   logic                 locked_q, locked_d;

   logic [7:0]           mag;
   logic [16:0]          avg_sum;
   logic [15:0]          avg_upd;
   logic                 railed;
   logic                 good;
   logic                 bad;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [CNT_WIDTH-1:0] lock_req;
   logic [CNT_WIDTH-1:0] unlock_req;

   // Datapath: magnitude, leaky filter, rail and threshold decisions
   always_comb begin
      mag        = error[7] ? 8'(~error + 8'd1) : error;
      avg_sum    = {1'b0, avg_q} - {1'b0, (avg_q >> AVG_SHIFT)}
                 + {9'd0, mag};
      avg_upd    = avg_sum[16] ? 16'hFFFF : avg_sum[15:0];
      railed     = (lagAccum == limit) || (lagAccum == (32'd0 - limit));
      good       = avg_q < lockThresh;
      bad        = avg_q > unlockThresh;
      cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
      lock_req   = (lockCount == '0) ? CNT_ONE : lockCount;
      unlock_req = (unlockCount == '0) ? CNT_ONE : unlockCount;
   end

   // Next-state and registered-output values for the acquisition FSM
   always_comb begin
      state_d = state_q;
      avg_d   = avg_q;
      cnt_d   = cnt_q;
      if (!enable) begin
         state_d = IDLE;
         avg_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               avg_d   = '0;
               cnt_d   = '0;
               state_d = SWEEP;
            end
            SWEEP: begin
               avg_d = avg_upd;
               cnt_d = '0;
               if (good && !railed)
                  state_d = VERIFY;
            end
            VERIFY: begin
               avg_d = avg_upd;
               if (railed || !good) begin
                  state_d = SWEEP;
                  cnt_d   = '0;
               end else if (cnt_inc >= lock_req) begin
                  state_d = LOCKED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            LOCKED: begin
               avg_d = avg_upd;
               if (!bad) begin
                  cnt_d = '0;
               end else if (cnt_inc >= unlock_req) begin
                  state_d = SWEEP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = IDLE;
               avg_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
      sweep_d  = (state_d == SWEEP) ? sweepRate : '0;
      locked_d = (state_d == LOCKED);
   end

   // State and output registers, advancing only on sample strobes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         avg_q    <= '0;
         cnt_q    <= '0;
         sweep_q  <= '0;
         locked_q <= 1'b0;
      end else if (clkEn) begin
         state_q  <= state_d;
         avg_q    <= avg_d;
         cnt_q    <= cnt_d;
         sweep_q  <= sweep_d;
         locked_q <= locked_d;
      end
   end

   assign state          = state_q;
   assign avgErrMag      = avg_q;
   assign sweepOffsetMag = sweep_q;
   assign locked         = locked_q;

endmodule

// File: tb/tb_loop_lock_monitor.sv
// Bench for loop_lock_monitor.
// Directed plan steps plus randomized traffic against a model.
module tb_loop_lock_monitor;

   localparam int K  = 6;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          clkEn;
   logic          enable;
   logic [7:0]    error;
   logic [31:0]   lagAccum;
   logic [31:0]   limit;
   logic [31:0]   sweepRate;
   logic [15:0]   lockThresh;
   logic [15:0]   unlockThresh;
   logic [CW-1:0] lockCount;
   logic [CW-1:0] unlockCount;
   logic [31:0]   sweepOffsetMag;
   logic          locked;
   logic [1:0]    state;
   logic [15:0]   avgErrMag;

   loop_lock_monitor #(.AVG_SHIFT(K), .CNT_WIDTH(CW)) dut (
      .clk(clk),
      .reset(reset),
      .clkEn(clkEn),
      .enable(enable),
      .error(error),
      .lagAccum(lagAccum),
      .limit(limit),
      .sweepRate(sweepRate),
      .lockThresh(lockThresh),
      .unlockThresh(unlockThresh),
      .lockCount(lockCount),
      .unlockCount(unlockCount),
      .sweepOffsetMag(sweepOffsetMag),
      .locked(locked),
      .state(state),
      .avgErrMag(avgErrMag)
   );

   // Free-running clock
   always #5 clk = ~clk;

   int checks  = 0;
   int errors  = 0;
   int samples = 0;
   bit quarter = 0;

   int          m_state;
   int          m_avg;
   int          m_cnt;
   logic [31:0] m_sweep;
   bit          m_locked;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state  = 0;
      m_avg    = 0;
      m_cnt    = 0;
      m_sweep  = '0;
      m_locked = 0;
   endtask

   // One clkEn sample of the lock supervisor, from the rules
   task automatic model_step();
      int e, mag, nxt_avg, lreq, ureq, c, cmax;
      bit good, bad, railed;
      logic [31:0] neg_lim;
      e       = int'($signed(error));
      mag     = (e < 0) ? -e : e;
      nxt_avg = m_avg + mag - m_avg / (1 << K);
      if (nxt_avg > 65535) nxt_avg = 65535;
      good    = m_avg < int'(lockThresh);
      bad     = m_avg > int'(unlockThresh);
      neg_lim = ~limit + 32'd1;
      railed  = (lagAccum == limit) || (lagAccum == neg_lim);
      lreq    = (lockCount == 0) ? 1 : int'(lockCount);
      ureq    = (unlockCount == 0) ? 1 : int'(unlockCount);
      cmax    = (1 << CW) - 1;
      c       = (m_cnt + 1 > cmax) ? cmax : m_cnt + 1;
      if (!enable) begin
         m_state = 0;
         m_avg   = 0;
         m_cnt   = 0;
      end else begin
         case (m_state)
            0: m_state = 1;
            1: begin
               m_avg = nxt_avg;
               m_cnt = 0;
               if (good && !railed) m_state = 2;
            end
            2: begin
               m_avg = nxt_avg;
               if (railed || !good) begin
                  m_state = 1;
                  m_cnt   = 0;
               end else if (c >= lreq) begin
                  m_state = 3;
                  m_cnt   = 0;
               end else m_cnt = c;
            end
            default: begin
               m_avg = nxt_avg;
               if (!bad) m_cnt = 0;
               else if (c >= ureq) begin
                  m_state = 1;
                  m_cnt   = 0;
               end else m_cnt = c;
            end
         endcase
      end
      m_sweep  = (m_state == 1) ? sweepRate : 32'd0;
      m_locked = (m_state == 3);
   endtask

   // One clock: model follows the edge, outputs compared 1 ns later
   task automatic cyc();
      @(posedge clk);
      if (clkEn && reset) begin
         model_step();
         samples++;
      end
      #1;
      chk("state", 32'(state), 32'(m_state));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("sweep", sweepOffsetMag, m_sweep);
      chk("avg", 32'(avgErrMag), 32'(m_avg));
      clkEn = quarter ? ($urandom_range(3) == 0) : 1'b1;
   endtask

   task automatic wait_state(input string tag, input logic [1:0] want,
                             input int budget);
      int n;
      n = 0;
      while (state !== want && n < budget) begin
         cyc();
         n++;
      end
      chk(tag, 32'(state), 32'(want));
   endtask

   // Bound on total runtime
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Directed plan followed by randomized traffic
   initial begin
      int s0, n, regime;
      reset        = 1'b0;
      clkEn        = 1'b1;
      enable       = 1'b0;
      error        = 8'd0;
      lagAccum     = 32'h0000_1234;
      limit        = 32'h0010_0000;
      sweepRate    = 32'h0000_1000;
      lockThresh   = 16'h0000;
      unlockThresh = 16'h1000;
      lockCount    = 16'd100;
      unlockCount  = 16'd8;
      model_reset();
      #12;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_sweep", sweepOffsetMag, 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_avg", 32'(avgErrMag), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) cyc();
      chk("idle_hold", 32'(state), 32'd0);

      // Sweep with a large error; filter converges to 40*64
      enable = 1'b1;
      error  = 8'd40;
      cyc();
      chk("p2_sweep", 32'(state), 32'd1);
      chk("p2_rate", sweepOffsetMag, 32'h1000);
      repeat (800) cyc();
      chk("p2_avg", 32'(avgErrMag), 32'd2560);
      lockThresh = 16'h0800;
      repeat (20) cyc();
      chk("p2_stay", 32'(state), 32'd1);
      error = 8'd2;
      wait_state("p2_verify", 2'd2, 200);
      chk("p2_vsweep", sweepOffsetMag, 32'd0);

      // Lock after exactly lockCount samples
      s0 = samples;
      wait_state("p3_lock", 2'd3, 300);
      chk("p3_count", 32'(samples - s0), 32'd100);
      chk("p3_locked", 32'(locked), 32'd1);

      // Same at quarter clkEn duty
      enable = 1'b0;
      wait_state("p3_idle", 2'd0, 10);
      quarter = 1;
      enable  = 1'b1;
      wait_state("p3q_verify", 2'd2, 400);
      s0 = samples;
      wait_state("p3q_lock", 2'd3, 2000);
      chk("p3q_count", 32'(samples - s0), 32'd100);
      quarter = 0;
      clkEn   = 1'b1;

      // Rail alone does not drop lock
      lagAccum = limit;
      repeat (5) cyc();
      lagAccum = 32'hFFF0_0000;
      repeat (5) cyc();
      chk("rail_locked", 32'(state), 32'd3);
      lagAccum = 32'h0000_1234;

      // Rail during VERIFY forces a return to sweep
      enable = 1'b0;
      wait_state("p4_idle", 2'd0, 10);
      enable = 1'b1;
      wait_state("p4_verify", 2'd2, 20);
      repeat (3) cyc();
      lagAccum = 32'hFFF0_0000;
      cyc();
      chk("p4_rail", 32'(state), 32'd1);
      chk("p4_rate", sweepOffsetMag, 32'h1000);
      lagAccum = 32'h0000_1234;

      // Loss of lock after unlockCount bad samples, with restart
      lockCount = 16'd4;
      wait_state("p5_lock", 2'd3, 40);
      error = 8'h80;
      n = 0;
      while (avgErrMag <= 16'h1000 && n < 500) begin
         cyc();
         n++;
      end
      chk("p5_bad", 32'(avgErrMag > 16'h1000), 32'd1);
      repeat (5) cyc();
      chk("p5_hold5", 32'(locked), 32'd1);
      unlockThresh = 16'hFFFF;
      cyc();
      unlockThresh = 16'h1000;
      repeat (7) cyc();
      chk("p5_hold7", 32'(locked), 32'd1);
      cyc();
      chk("p5_drop", 32'(locked), 32'd0);
      chk("p5_sweep", 32'(state), 32'd1);

      // Asynchronous reset pulse between edges
      error = 8'd2;
      wait_state("p6_lock", 2'd3, 400);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("p6_state", 32'(state), 32'd0);
      chk("p6_locked", 32'(locked), 32'd0);
      chk("p6_sweep", sweepOffsetMag, 32'd0);
      chk("p6_avg", 32'(avgErrMag), 32'd0);
      #2;
      reset = 1'b1;

      // Disable during VERIFY
      wait_state("p6_verify", 2'd2, 20);
      repeat (2) cyc();
      enable = 1'b0;
      cyc();
      chk("p6_idle", 32'(state), 32'd0);
      chk("p6_idle_avg", 32'(avgErrMag), 32'd0);

      // Randomized traffic
      enable = 1'b1;
      regime = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 120 == 0) regime = int'($urandom_range(2));
         case (regime)
            0: error = 8'($urandom_range(0, 5));
            1: error = 8'($urandom_range(100, 128));
            default: error = 8'($urandom);
         endcase
         if ($urandom_range(1) == 1) error = 8'(~error + 8'd1);
         enable = ($urandom_range(299) != 0);
         if ($urandom_range(49) == 0)
            lockThresh = 16'($urandom_range(16'h0400, 16'h0C00));
         if ($urandom_range(49) == 0)
            unlockThresh = 16'($urandom_range(16'h0800, 16'h2000));
         if ($urandom_range(49) == 0) lockCount = 16'($urandom_range(0, 6));
         if ($urandom_range(49) == 0) unlockCount = 16'($urandom_range(0, 6));
         if ($urandom_range(29) == 0) sweepRate = $urandom;
         case ($urandom_range(19))
            0: lagAccum = limit;
            1: lagAccum = ~limit + 32'd1;
            default: lagAccum = $urandom;
         endcase
         clkEn = ($urandom_range(3) != 0);
         cyc();
         if ($urandom_range(599) == 0) begin
            #2;
            reset = 1'b0;
            #1;
            model_reset();
            chk("rnd_rst", 32'(state), 32'd0);
            #2;
            reset = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/loop_lock_monitor.md
Name: loop_lock_monitor

Overview:
Lock supervisor for the carrier/bit-sync loop filter. It reads the 8-bit loop error and the lag integrator accumulator, keeps a smoothed error magnitude, and runs an acquisition state machine. That state machine drives the sweep offset magnitude back into the lag integrator and reports lock status. It sits beside the lag integrator on the same clkEn sample rate.

Parameters:
AVG_SHIFT, 6, leaky-integrator shift K; filtered magnitude is about 2^K times the mean |error|.
CNT_WIDTH, 16, width of the lock/unlock qualification counters.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
clkEn  in  1  sample strobe; all state advances only when high
enable  in  1  loop enable; low forces IDLE
error  in  8  signed two's-complement loop error
lagAccum  in  32  signed lag integrator value
limit  in  32  positive lag limit, the same value the lag integrator uses
sweepRate  in  32  sweep magnitude applied while searching
lockThresh  in  16  filtered-magnitude threshold for lock
unlockThresh  in  16  filtered-magnitude threshold for loss of lock
lockCount  in  CNT_WIDTH  qualifying samples required to declare lock
unlockCount  in  CNT_WIDTH  consecutive bad samples required to drop lock
sweepOffsetMag  out  32  sweep magnitude sent to the lag integrator
locked  out  1  lock indicator
state  out  2  0=IDLE 1=SWEEP 2=VERIFY 3=LOCKED
avgErrMag  out  16  filtered |error|

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, avgErrMag=0, counters=0, sweepOffsetMag=0, locked=0.
- All registers update only on clk edges with clkEn=1. When clkEn=0, every register holds.
- Outputs are registered. Each output reflects the clkEn sample taken one clock earlier.
- Magnitude: mag = |error| as 8-bit unsigned, so -128 gives 128 and 0x80 must not wrap to 0.
- Filter: avgErrMag <= avgErrMag + mag - (avgErrMag >> AVG_SHIFT), unsigned, saturating at 0xFFFF. Steady state for constant mag m is m*2^K.
- Rail detect: railed = (lagAccum == limit) or (lagAccum == -limit), using 32-bit two's-complement comparison.
- good = avgErrMag < lockThresh. bad = avgErrMag > unlockThresh. Both use the registered avgErrMag from before the current update.
- lockCount=0 and unlockCount=0 are each treated as 1.
- IDLE:
  - sweepOffsetMag=0, locked=0, avg and counters held at 0.
  - enable=1 -> SWEEP.
- SWEEP:
  - sweepOffsetMag=sweepRate, locked=0, cnt=0.
  - good and not railed -> VERIFY.
- VERIFY:
  - sweepOffsetMag=0, locked=0.
  - Priority: railed -> SWEEP (false lock at rail), else not good -> SWEEP, else cnt+1.
  - When cnt+1 reaches lockCount -> LOCKED, cnt=0.
- LOCKED:
  - sweepOffsetMag=0, locked=1.
  - bad -> cnt+1; not bad -> cnt=0.
  - When cnt+1 reaches unlockCount -> SWEEP, and locked drops on the same edge.
  - Rail alone does not drop lock.
- enable=0 in any state, on a clkEn edge -> IDLE, avgErrMag=0, cnt=0. This overrides all other transitions.
- Counter saturates at all-ones and never wraps.
- Changing a threshold or count mid-state takes effect on the next clkEn sample. No re-qualification is restarted.
- Reset asserted mid-operation returns immediately to IDLE values, independent of clkEn.

Test Plan:
1. Reset low, then high, with enable=0 and clkEn=1 -> state=0, sweepOffsetMag=0, locked=0, avgErrMag=0 indefinitely.
2. enable=1, sweepRate=0x1000, error=+40 constant, lockThresh=0x0800 -> SWEEP with sweepOffsetMag=0x1000; avgErrMag converges toward 2560 and stays in SWEEP. Then switch error to +2 -> avg decays below 0x0800, VERIFY, sweepOffsetMag=0.
3. From VERIFY with good error, lockCount=100 -> locked=1 and state=3 exactly 100 clkEn samples after VERIFY entry. Repeat with clkEn at 1/4 duty and check the same sample count.
4. From VERIFY, limit=0x00100000, drive lagAccum=0xFFF00000 -> SWEEP on the next clkEn edge, sweepOffsetMag=sweepRate, even though good=1.
5. From LOCKED, unlockThresh=0x1000, unlockCount=8, error=-128 constant -> once avg>0x1000, locked drops after 8 consecutive bad samples. Inserting one good-region sample at count 5 must restart the count.
6. From LOCKED, pulse reset low for 3 ns between clk edges -> all outputs return to reset values immediately. Also deassert enable during VERIFY -> IDLE on the next clkEn edge, with avgErrMag=0.
